// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit:
// FSM states, opcodes, ALU codes and datapath mux selects.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBeq,
    StJal
  } state_e;

  localparam logic [6:0] OpLw  = 7'b0000011;
  localparam logic [6:0] OpSw  = 7'b0100011;
  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpBeq = 7'b1100011;
  localparam logic [6:0] OpJal = 7'b1101111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  // Coarse ALU request from the FSM; AluOpFunct defers to funct3/funct7.
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic AdrPc  = 1'b0;
  localparam logic AdrAlu = 1'b1;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARd1   = 2'b10;

  localparam logic [1:0] SrcBRd2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  function automatic logic [1:0] imm_src(input logic [6:0] opcode);
    logic [1:0] sel;
    unique case (opcode)
      OpSw:    sel = ImmS;
      OpBeq:   sel = ImmB;
      OpJal:   sel = ImmJ;
      default: sel = ImmI;
    endcase
    return sel;
  endfunction

  function automatic logic op_supported(input logic [6:0] opcode);
    return (opcode == OpLw) || (opcode == OpSw) || (opcode == OpR) ||
           (opcode == OpI) || (opcode == OpBeq) || (opcode == OpJal);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from the FSM's coarse request plus
// funct3 / funct7[5].
module alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [1:0] aluOp,
  input  logic       op5,
  input  logic [2:0] f3,
  input  logic       f7,
  output logic [2:0] aluControl
);

  always_comb begin
    aluControl = AluAdd;
    case (aluOp)
      AluOpAdd: aluControl = AluAdd;
      AluOpSub: aluControl = AluSub;
      default: begin
        case (f3)
          // op5 separates R-type from I-type: addi has no subtract form.
          3'b000:  aluControl = (op5 && f7) ? AluSub : AluAdd;
          3'b010:  aluControl = AluSlt;
          3'b110:  aluControl = AluOr;
          3'b111:  aluControl = AluAnd;
          default: aluControl = AluAdd;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM: sequences the shared datapath, counts
// retired instructions and flags unsupported opcodes.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic        clk,
  input  logic        rstN,
  input  logic [6:0]  op,
  input  logic [2:0]  f3,
  input  logic        f7,
  input  logic        zero,
  output logic        pcWrite,
  output logic        adrSrc,
  output logic        memWrite,
  output logic        irWrite,
  output logic [1:0]  resSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUControl,
  output logic [1:0]  inmSrc,
  output logic        regWrite,
  output logic [31:0] instret,
  output logic        illegal
);

  state_e      r_state;
  state_e      w_next;
  logic [31:0] r_instret;
  logic        r_illegal;

  logic        w_pc_write;
  logic        w_mem_write;
  logic        w_ir_write;
  logic        w_reg_write;
  logic        w_adr_src;
  logic [1:0]  w_res_src;
  logic [1:0]  w_src_a;
  logic [1:0]  w_src_b;
  logic [1:0]  w_alu_op;
  logic        w_retire;
  logic        w_bad_op;

  always_comb begin
    w_next = StFetch;
    unique case (r_state)
      StFetch:  w_next = StDecode;
      StDecode: begin
        unique case (op)
          OpLw, OpSw: w_next = StMemAdr;
          OpR:        w_next = StExecR;
          OpI:        w_next = StExecI;
          OpBeq:      w_next = StBeq;
          OpJal:      w_next = StJal;
          default:    w_next = StFetch;
        endcase
      end
      StMemAdr:                 w_next = (op == OpSw) ? StMemWrite : StMemRead;
      StMemRead:                w_next = StMemWb;
      StExecR, StExecI, StJal:  w_next = StAluWb;
      default:                  w_next = StFetch;
    endcase
  end

  always_comb begin
    w_pc_write  = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    w_adr_src   = AdrPc;
    w_res_src   = ResAluOut;
    w_src_a     = SrcAPc;
    w_src_b     = SrcBRd2;
    w_alu_op    = AluOpAdd;
    unique case (r_state)
      StFetch: begin
        w_ir_write = 1'b1;
        w_pc_write = 1'b1;
        w_src_b    = SrcBFour;
        w_res_src  = ResAluResult;
      end
      StDecode: begin
        w_src_a = SrcAOldPc;
        w_src_b = SrcBImm;
      end
      StMemAdr: begin
        w_src_a = SrcARd1;
        w_src_b = SrcBImm;
      end
      StMemRead: w_adr_src = AdrAlu;
      StMemWb: begin
        w_res_src   = ResData;
        w_reg_write = 1'b1;
      end
      StMemWrite: begin
        w_adr_src   = AdrAlu;
        w_mem_write = 1'b1;
      end
      StExecR: begin
        w_src_a  = SrcARd1;
        w_alu_op = AluOpFunct;
      end
      StExecI: begin
        w_src_a  = SrcARd1;
        w_src_b  = SrcBImm;
        w_alu_op = AluOpFunct;
      end
      StAluWb: w_reg_write = 1'b1;
      StBeq: begin
        w_src_a    = SrcARd1;
        w_alu_op   = AluOpSub;
        w_pc_write = zero;
      end
      StJal: begin
        w_src_a    = SrcAOldPc;
        w_src_b    = SrcBFour;
        w_pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluOp      (w_alu_op),
    .op5        (op[5]),
    .f3         (f3),
    .f7         (f7),
    .aluControl (ALUControl)
  );

  assign w_retire = (r_state == StMemWb) || (r_state == StMemWrite) ||
                    (r_state == StAluWb) || (r_state == StBeq);
  assign w_bad_op = (r_state == StDecode) && !op_supported(op);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state   <= StFetch;
      r_instret <= 32'd0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instret <= r_instret + 32'd1;
      if (w_bad_op) r_illegal <= 1'b1;
    end
  end

  // Write enables are gated by reset so nothing commits while it is held;
  // the remaining selects already show FETCH since the state resets there.
  assign pcWrite  = w_pc_write & rstN;
  assign memWrite = w_mem_write & rstN;
  assign irWrite  = w_ir_write & rstN;
  assign regWrite = w_reg_write & rstN;
  assign adrSrc   = w_adr_src;
  assign resSrc   = w_res_src;
  assign ALUSrcA  = w_src_a;
  assign ALUSrcB  = w_src_b;
  assign inmSrc   = imm_src(op);
  assign instret  = r_instret;
  assign illegal  = r_illegal;

endmodule
